// File: rtl/sp_ram_arbiter_if.sv
// Request/grant/response bundle for one master of the RAM arbiter.
// The master drives the request side; the arbiter drives grant and response.
interface sp_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    gnt;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port RAM with
// one-cycle read latency. Grants are combinational, one access per cycle,
// and each granted access gets an rvalid pulse the following cycle.
module sp_ram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  sp_ram_arbiter_if.slave         m0,
  sp_ram_arbiter_if.slave         m1,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // Arbitration state: who is preferred on contention, who owns the
  // in-flight response, and whether a response is due this cycle.
  logic r_prio;
  logic r_owner;
  logic r_valid;

  logic w_req0;
  logic w_req1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_any_gnt;

  // Requests are masked while reset is asserted so nothing reaches the RAM
  // (in particular no write) once rstn_i has fallen.
  assign w_req0 = m0.req & rstn_i;
  assign w_req1 = m1.req & rstn_i;

  // A lone requester always wins; on contention the preferred master wins.
  assign w_gnt0    = w_req0 & (~w_req1 | ~r_prio);
  assign w_gnt1    = w_req1 & (~w_req0 |  r_prio);
  assign w_any_gnt = w_gnt0 | w_gnt1;

  assign m0.gnt = w_gnt0;
  assign m1.gnt = w_gnt1;

  // RAM-side mux: the granted master's fields, or all zeros when idle.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (w_gnt0) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = m0.addr;
      ram_we_o    = m0.we;
      ram_be_o    = m0.be;
      ram_wdata_o = m0.wdata;
    end else if (w_gnt1) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = m1.addr;
      ram_we_o    = m1.we;
      ram_be_o    = m1.be;
      ram_wdata_o = m1.wdata;
    end
  end

  // Update priority and in-flight response tracking on every cycle.
  // Priority flips to the loser of each grant; it holds when nothing is granted.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_prio  <= 1'b0;
      r_owner <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_any_gnt) begin
      r_prio  <= ~w_gnt1;
      r_owner <= w_gnt1;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  // Route the response to the master that owns the access in flight.
  // Write responses carry whatever the RAM still presents; masters ignore it.
  logic w_rvalid0;
  logic w_rvalid1;

  assign w_rvalid0 = r_valid & ~r_owner;
  assign w_rvalid1 = r_valid &  r_owner;

  assign m0.rvalid = w_rvalid0;
  assign m1.rvalid = w_rvalid1;
  assign m0.rdata  = w_rvalid0 ? ram_rdata_i : {DATA_WIDTH{1'b0}};
  assign m1.rdata  = w_rvalid1 ? ram_rdata_i : {DATA_WIDTH{1'b0}};

  // Byte-enable width is implied by the data width; keep it visible for readers.
  logic [BE_WIDTH-1:0] w_be_unused;
  assign w_be_unused = '0;

endmodule
